// File: rtl/text_overlay.sv
// Text overlay: renders a string of 5x5 glyphs over the scan position with a 2-cycle registered latency.
// Optional frame-counter blink is compiled in with `define TEXT_BLINK_EN.
module text_overlay #(
    parameter int MAX_CHARS = 8,
    parameter int SCALE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_char,
    input  logic       commit,
    input  logic [9:0] cfg_x,
    input  logic [9:0] cfg_y,
    input  logic [1:0] cfg_scale,
    input  logic [4:0] cfg_len,
    input  logic       blink,
    output logic       commit_pending,
    output logic       text_pixel
);

    localparam logic [4:0] MAX_LEN   = 5'(MAX_CHARS);
    localparam logic [1:0] SCALE_LIM = (SCALE_MAX > 3) ? 2'd3 : 2'(SCALE_MAX);
    localparam logic [5:0] BLANK     = 6'd63;

    function automatic logic [1:0] clamp_scale(input logic [1:0] s);
        return (s > SCALE_LIM) ? SCALE_LIM : s;
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    // Row-major bitmap: row 0 in bits [24:20], leftmost column is the MSB of each row.
    function automatic logic [24:0] glyph_rows(input logic [5:0] code);
        case (code)
            6'd0:  return 25'b01110_10011_10101_11001_01110;
            6'd1:  return 25'b00100_01100_00100_00100_01110;
            6'd2:  return 25'b11110_00001_01110_10000_11111;
            6'd3:  return 25'b11110_00001_00110_00001_11110;
            6'd4:  return 25'b10010_10010_11111_00010_00010;
            6'd5:  return 25'b11111_10000_11110_00001_11110;
            6'd6:  return 25'b01110_10000_11110_10001_01110;
            6'd7:  return 25'b11111_00001_00010_00100_00100;
            6'd8:  return 25'b01110_10001_01110_10001_01110;
            6'd9:  return 25'b01110_10001_01111_00001_01110;
            6'd10: return 25'b01110_10001_11111_10001_10001;
            6'd11: return 25'b11110_10001_11110_10001_11110;
            6'd12: return 25'b01111_10000_10000_10000_01111;
            6'd13: return 25'b11110_10001_10001_10001_11110;
            6'd14: return 25'b11111_10000_11110_10000_11111;
            6'd15: return 25'b11111_10000_11110_10000_10000;
            6'd16: return 25'b01111_10000_10011_10001_01111;
            6'd17: return 25'b10001_10001_11111_10001_10001;
            6'd18: return 25'b11111_00100_00100_00100_11111;
            6'd19: return 25'b00111_00010_00010_10010_01100;
            6'd20: return 25'b10010_10100_11000_10100_10010;
            6'd21: return 25'b10000_10000_10000_10000_11111;
            6'd22: return 25'b10001_11011_10101_10001_10001;
            6'd23: return 25'b10001_11001_10101_10011_10001;
            6'd24: return 25'b01110_10001_10001_10001_01110;
            6'd25: return 25'b11110_10001_11110_10000_10000;
            6'd26: return 25'b01110_10001_10101_10010_01101;
            6'd27: return 25'b11110_10001_11110_10100_10010;
            6'd28: return 25'b01111_10000_01110_00001_11110;
            6'd29: return 25'b11111_00100_00100_00100_00100;
            6'd30: return 25'b10001_10001_10001_10001_01110;
            6'd31: return 25'b10001_10001_10001_01010_00100;
            6'd32: return 25'b10001_10001_10101_11011_10001;
            6'd33: return 25'b10001_01010_00100_01010_10001;
            6'd34: return 25'b10001_01010_00100_00100_00100;
            6'd35: return 25'b11111_00010_00100_01000_11111;
            6'd36: return 25'b00100_00100_00100_00000_00100;
            default: return 25'd0;
        endcase
    endfunction

    function automatic logic glyph_bit(input logic [5:0] code, input logic [2:0] row,
                                       input logic [2:0] col);
        logic [24:0] rows;
        logic [4:0]  idx;
        rows = glyph_rows(code);
        idx  = 5'd24 - (5'd5 * {2'b00, row}) - {2'b00, col};
        return rows[idx];
    endfunction

    logic [5:0] shadow_q [16];
    logic [5:0] shadow_d [16];
    logic [5:0] active_q [16];
    logic [5:0] active_d [16];
    logic [9:0] ax_q, ax_d, ay_q, ay_d;
    logic [1:0] as_q, as_d;
    logic [4:0] alen_q, alen_d;
    logic       commit_pending_q, commit_pending_d;
    logic       vld_p0_q, vld_p0_d;
    logic [3:0] cell_p0_q, cell_p0_d;
    logic [2:0] gcol_p0_q, gcol_p0_d;
    logic [2:0] grow_p0_q, grow_p0_d;
    logic       text_pixel_q, text_pixel_d;
    logic [9:0] rx, ry, gx, gy, cell_idx;
    logic [5:0] code_p1;
`ifdef TEXT_BLINK_EN
    logic [5:0] blink_cnt_q, blink_cnt_d;
`else
    logic       blink_unused;
    assign blink_unused = blink;
`endif

    always_comb begin
        shadow_d         = shadow_q;
        active_d         = active_q;
        ax_d             = ax_q;
        ay_d             = ay_q;
        as_d             = as_q;
        alen_d           = alen_q;
        commit_pending_d = commit_pending_q;

        // Publish reads shadow_q, so a coincident write only reaches the shadow.
        if (frame_start && commit_pending_q) begin
            active_d         = shadow_q;
            ax_d             = cfg_x;
            ay_d             = cfg_y;
            as_d             = clamp_scale(cfg_scale);
            alen_d           = clamp_len(cfg_len);
            commit_pending_d = 1'b0;
        end
        if (commit) begin
            commit_pending_d = 1'b1;
        end
        if (wr_en && ({1'b0, wr_addr} < MAX_LEN)) begin
            shadow_d[wr_addr] = wr_char;
        end

        // Stage p0: position to cell / glyph coordinates
        rx        = xCount - ax_q;
        ry        = yCount - ay_q;
        gx        = rx >> as_q;
        gy        = ry >> as_q;
        cell_idx  = gx / 10'd6;
        vld_p0_d  = (xCount >= ax_q) && (yCount >= ay_q) && (gy < 10'd5)
                    && (cell_idx < {5'd0, alen_q});
        cell_p0_d = cell_idx[3:0];
        gcol_p0_d = 3'(gx % 10'd6);
        grow_p0_d = gy[2:0];

        // Stage p1: character lookup and glyph bit
        code_p1      = active_q[cell_p0_q];
        text_pixel_d = vld_p0_q && (gcol_p0_q < 3'd5) && glyph_bit(code_p1, grow_p0_q, gcol_p0_q);
`ifdef TEXT_BLINK_EN
        blink_cnt_d = frame_start ? blink_cnt_q + 6'd1 : blink_cnt_q;
        if (blink && blink_cnt_q[5]) begin
            text_pixel_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= BLANK;
                active_q[i] <= BLANK;
            end
            ax_q             <= 10'd200;
            ay_q             <= 10'd200;
            as_q             <= 2'd0;
            alen_q           <= 5'd0;
            commit_pending_q <= 1'b0;
            vld_p0_q         <= 1'b0;
            cell_p0_q        <= 4'd0;
            gcol_p0_q        <= 3'd0;
            grow_p0_q        <= 3'd0;
            text_pixel_q     <= 1'b0;
`ifdef TEXT_BLINK_EN
            blink_cnt_q      <= 6'd0;
`endif
        end else begin
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            ax_q             <= ax_d;
            ay_q             <= ay_d;
            as_q             <= as_d;
            alen_q           <= alen_d;
            commit_pending_q <= commit_pending_d;
            vld_p0_q         <= vld_p0_d;
            cell_p0_q        <= cell_p0_d;
            gcol_p0_q        <= gcol_p0_d;
            grow_p0_q        <= grow_p0_d;
            text_pixel_q     <= text_pixel_d;
`ifdef TEXT_BLINK_EN
            blink_cnt_q      <= blink_cnt_d;
`endif
        end
    end

    assign commit_pending = commit_pending_q;
    assign text_pixel     = text_pixel_q;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: rendering, scaling, shadow/commit behaviour, reset and blink.
module tb_text_overlay;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] xCount, yCount;
    logic       frame_start, wr_en, commit, blink;
    logic [3:0] wr_addr;
    logic [5:0] wr_char;
    logic [9:0] cfg_x, cfg_y;
    logic [1:0] cfg_scale;
    logic [4:0] cfg_len;
    logic       commit_pending, text_pixel;

    int vectors     = 0;
    int miscompares = 0;
    int fcount      = 0;

    always #5 clk = ~clk;

    text_overlay #(.MAX_CHARS(8), .SCALE_MAX(3)) dut (
        .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .commit(commit), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
        .cfg_len(cfg_len), .blink(blink), .commit_pending(commit_pending),
        .text_pixel(text_pixel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic p);
        xCount = x;
        yCount = y;
        tick;
        tick;
        p = text_pixel;
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic set_cfg(input logic [9:0] x, input logic [9:0] y, input logic [1:0] s,
                           input logic [4:0] l);
        cfg_x = x; cfg_y = y; cfg_scale = s; cfg_len = l;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        fcount++;
    endtask

    task automatic req_commit;
        commit = 1'b1;
        tick;
        commit = 1'b0;
    endtask

    task automatic test_reset;
        logic p;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        fcount = 0;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL reset_pending got %b want 0", commit_pending);
        end
        vectors++;
        if (text_pixel !== 1'b0) begin
            miscompares++; $display("FAIL reset_pixel got %b want 0", text_pixel);
        end
        probe(10'd200, 10'd200, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++; $display("FAIL reset_empty got %b want 0", p);
        end
    endtask

    task automatic test_render;
        int   xs [11] = '{230, 235, 232, 232, 237, 238, 250, 250, 229, 230, 254};
        int   ys [11] = '{230, 230, 230, 232, 231, 231, 233, 234, 230, 235, 230};
        logic ex [11] = '{1,   0,   0,   1,   0,   1,   0,   1,   0,   0,   0};
        logic p;
        wr(4'd0, 6'd32); wr(4'd1, 6'd18); wr(4'd2, 6'd23); wr(4'd3, 6'd36);
        set_cfg(10'd230, 10'd230, 2'd0, 5'd4);
        req_commit;
        vectors++;
        if (commit_pending !== 1'b1) begin
            miscompares++; $display("FAIL render_pending_set got %b want 1", commit_pending);
        end
        frame;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL render_pending_clr got %b want 0", commit_pending);
        end
        for (int i = 0; i < 11; i++) begin
            probe(10'(xs[i]), 10'(ys[i]), p);
            vectors++;
            if (p !== ex[i]) begin
                miscompares++;
                $display("FAIL render_pix (%0d,%0d) got %b want %b", xs[i], ys[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_scale;
        int   xs [5] = '{300, 303, 304, 307, 303};
        int   ys [5] = '{35,  54,  35,  54,  55};
        logic ex [5] = '{1,   1,   0,   1,   0};
        logic p;
        wr(4'd0, 6'd21);
        set_cfg(10'd300, 10'd35, 2'd2, 5'd1);
        req_commit;
        frame;
        for (int i = 0; i < 5; i++) begin
            probe(10'(xs[i]), 10'(ys[i]), p);
            vectors++;
            if (p !== ex[i]) begin
                miscompares++;
                $display("FAIL scale_pix (%0d,%0d) got %b want %b", xs[i], ys[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_shadow_isolation;
        logic p;
        wr(4'd0, 6'd10);
        frame;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL shadow_pending got %b want 0", commit_pending);
        end
        probe(10'd304, 10'd35, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++; $display("FAIL shadow_col1 got %b want 0", p);
        end
        probe(10'd300, 10'd35, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++; $display("FAIL shadow_col0 got %b want 1", p);
        end
    endtask

    task automatic test_len_clamp;
        int   xs [4] = '{42, 43, 48, 97};
        logic ex [4] = '{1,  1,  0,  0};
        logic p;
        wr(4'd7, 6'd18);
        wr(4'd8, 6'd18);
        set_cfg(10'd0, 10'd0, 2'd0, 5'd20);
        req_commit;
        frame;
        for (int i = 0; i < 4; i++) begin
            probe(10'(xs[i]), 10'd0, p);
            vectors++;
            if (p !== ex[i]) begin
                miscompares++;
                $display("FAIL lenclamp_pix x=%0d got %b want %b", xs[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_race;
        logic p;
        set_cfg(10'd0, 10'd100, 2'd0, 5'd2);
        req_commit;
        frame_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_char = 6'd23;
        tick;
        frame_start = 1'b0; wr_en = 1'b0;
        fcount++;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL race_pending got %b want 0", commit_pending);
        end
        probe(10'd7, 10'd100, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++; $display("FAIL race_old_cell got %b want 1", p);
        end
        req_commit;
        frame;
        probe(10'd7, 10'd100, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++; $display("FAIL race_new_r0 got %b want 0", p);
        end
        probe(10'd6, 10'd101, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++; $display("FAIL race_new_r1 got %b want 1", p);
        end
    endtask

    task automatic test_commit_coincide;
        logic p;
        set_cfg(10'd0, 10'd100, 2'd0, 5'd0);
        commit = 1'b1; frame_start = 1'b1;
        tick;
        commit = 1'b0; frame_start = 1'b0;
        fcount++;
        vectors++;
        if (commit_pending !== 1'b1) begin
            miscompares++; $display("FAIL coincide_pending got %b want 1", commit_pending);
        end
        probe(10'd6, 10'd101, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++; $display("FAIL coincide_nocopy got %b want 1", p);
        end
        frame;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL coincide_clear got %b want 0", commit_pending);
        end
        probe(10'd6, 10'd101, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++; $display("FAIL coincide_copied got %b want 0", p);
        end
    endtask

    task automatic test_reset_mid;
        logic p;
        set_cfg(10'd0, 10'd100, 2'd0, 5'd2);
        req_commit;
        vectors++;
        if (commit_pending !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_pending_set got %b want 1", commit_pending);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        fcount = 0;
        vectors++;
        if (commit_pending !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_pending got %b want 0", commit_pending);
        end
        vectors++;
        if (text_pixel !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_pixel got %b want 0", text_pixel);
        end
        frame;
        probe(10'd6, 10'd101, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_empty got %b want 0", p);
        end
        wr(4'd0, 6'd18);
        set_cfg(10'd0, 10'd100, 2'd0, 5'd1);
        req_commit;
        frame;
        probe(10'd0, 10'd100, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_recommit got %b want 1", p);
        end
    endtask

    task automatic test_blink;
        logic p, e;
        blink = 1'b1;
        for (int i = 0; i < 64; i++) begin
            probe(10'd0, 10'd100, p);
`ifdef TEXT_BLINK_EN
            e = (fcount[5] == 1'b1) ? 1'b0 : 1'b1;
`else
            e = 1'b1;
`endif
            vectors++;
            if (p !== e) begin
                miscompares++;
                $display("FAIL blink_frame %0d got %b want %b", fcount, p, e);
            end
            frame;
        end
        blink = 1'b0;
    endtask

    initial begin
        rst = 1'b1; xCount = '0; yCount = '0; frame_start = 1'b0; wr_en = 1'b0;
        commit = 1'b0; blink = 1'b0; wr_addr = '0; wr_char = '0;
        set_cfg(10'd0, 10'd0, 2'd0, 5'd0);
        test_reset;
        test_render;
        test_scale;
        test_shadow_isolation;
        test_len_clamp;
        test_race;
        test_commit_coincide;
        test_reset_mid;
        test_blink;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
